sram_word_ctrl: RTL and testbench

//   Parametrised controller between the datapath and an external asynchronous SRAM with a narrow data bus.

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_word_ctrl.sv | 156 +++++++++++++++
 tb/tb_sram_word_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the word-wide asynchronous SRAM controller.
package sram_pkg;

    typedef logic signed [15:0] num;

    typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} sram_state_t;

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned bus_w);
        return word_w / bus_w;
    endfunction

endpackage

// File: rtl/sram_word_ctrl.sv
// Moves one client word as a burst of narrow beats to or from an asynchronous SRAM,
// with wait states, a valid/ready request port and a write-to-read bus turnaround.
module sram_word_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 21,
    parameter int unsigned BUS_W    = 8,
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              busy_o,
    inout  wire  [BUS_W-1:0]  sram_data_io,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_ce_n_o,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o
);

    localparam int unsigned BEATS  = beats(WORD_W, BUS_W);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
    localparam int unsigned TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_CYC);
    localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    if ((WORD_W < BUS_W) || (WORD_W % BUS_W != 0)) begin : g_param_err
        $error("sram_word_ctrl: WORD_W must be a non-zero multiple of BUS_W");
    end

    sram_state_t       state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [WAIT_W-1:0] wait_q;
    logic [TURN_W-1:0] turn_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rbuf_q;
    logic [WORD_W-1:0] rdata_q;
    logic              rsp_valid_q;
    logic              ce_n_q;
    logic              we_n_q;
    logic              oe_n_q;
    logic              drive_q;
    logic [WORD_W-1:0] rd_shift_d;

    // Beats arrive LS-first, so each new slice enters at the top and shifts down.
    always_comb begin
        rd_shift_d = (rbuf_q >> BUS_W) | (WORD_W'(sram_data_io) << (WORD_W - BUS_W));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wait_q      <= '0;
            turn_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        beat_q  <= '0;
                        wait_q  <= '0;
                        ce_n_q  <= 1'b0;
                        if (req_write_i) begin
                            we_n_q  <= 1'b0;
                            drive_q <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            oe_n_q  <= 1'b0;
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wait_q == LAST_WAIT) begin
                        wait_q <= '0;
                        if (beat_q == LAST_BEAT) begin
                            ce_n_q  <= 1'b1;
                            we_n_q  <= 1'b1;
                            drive_q <= 1'b0;
                            turn_q  <= '0;
                            state_q <= (TURN_CYC > 0) ? TURN : IDLE;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            addr_q  <= addr_q + 1'b1;
                            wdata_q <= wdata_q >> BUS_W;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                READ: begin
                    if (wait_q == LAST_WAIT) begin
                        wait_q <= '0;
                        rbuf_q <= rd_shift_d;
                        if (beat_q == LAST_BEAT) begin
                            rdata_q     <= rd_shift_d;
                            rsp_valid_q <= 1'b1;
                            ce_n_q      <= 1'b1;
                            oe_n_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                TURN: begin
                    if (turn_q == LAST_TURN) begin
                        state_q <= IDLE;
                    end else begin
                        turn_q <= turn_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sram_data_io = drive_q ? wdata_q[BUS_W-1:0] : {BUS_W{1'bz}};

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_we_n_o = we_n_q;
    assign sram_oe_n_o = oe_n_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Scoreboard bench: two controllers (16-bit default, 32-bit no-wait with 2-cycle turnaround),
// each attached to a byte-array SRAM model.
module tb_sram_word_ctrl;

    localparam int unsigned LAT_A = 2 * (1 + 1);
    localparam int unsigned LAT_B = 4 * (1 + 0);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic        a_valid, a_write, a_ready, a_rsp_valid, a_busy, a_ce_n, a_we_n, a_oe_n;
    logic [20:0] a_addr, a_sram_addr;
    logic [15:0] a_wdata, a_rdata;
    wire  [7:0]  a_data;

    logic        b_valid, b_write, b_ready, b_rsp_valid, b_busy, b_ce_n, b_we_n, b_oe_n;
    logic [20:0] b_addr, b_sram_addr;
    logic [31:0] b_wdata, b_rdata;
    wire  [7:0]  b_data;

    sram_word_ctrl u_a (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_write_i(a_write),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata), .busy_o(a_busy),
        .sram_data_io(a_data), .sram_addr_o(a_sram_addr),
        .sram_ce_n_o(a_ce_n), .sram_we_n_o(a_we_n), .sram_oe_n_o(a_oe_n)
    );

    sram_word_ctrl #(
        .ADDR_W(21), .BUS_W(8), .WORD_W(32), .WAIT_CYC(0), .TURN_CYC(2)
    ) u_b (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_write_i(b_write),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata), .busy_o(b_busy),
        .sram_data_io(b_data), .sram_addr_o(b_sram_addr),
        .sram_ce_n_o(b_ce_n), .sram_we_n_o(b_we_n), .sram_oe_n_o(b_oe_n)
    );

    logic [7:0] mem_a [0:2097151];
    logic [7:0] mem_b [0:2097151];

    always @(posedge clk) begin
        if (!a_ce_n && !a_we_n) mem_a[a_sram_addr] <= a_data;
        if (!b_ce_n && !b_we_n) mem_b[b_sram_addr] <= b_data;
    end

    assign a_data = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_sram_addr] : 8'hzz;
    assign b_data = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_sram_addr] : 8'hzz;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;

    int acc_a = 0;
    int iss_a = 0;
    always @(posedge clk) if (a_valid && a_ready) acc_a <= acc_a + 1;

    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (sb_a.size() == 0) check_eq("a_unexpected_rsp", 32'd1, 32'd0);
            else begin
                ea = sb_a.pop_front();
                check_eq("a_rdata", 32'(a_rdata), ea.data);
                check_eq("a_rsp_cycle", cyc, ea.cyc);
            end
        end
        if (b_rsp_valid) begin
            if (sb_b.size() == 0) check_eq("b_unexpected_rsp", 32'd1, 32'd0);
            else begin
                eb = sb_b.pop_front();
                check_eq("b_rdata", b_rdata, eb.data);
                check_eq("b_rsp_cycle", cyc, eb.cyc);
            end
        end
    end

    // Called away from the rising edge; returns at a falling edge when wait_done is set,
    // otherwise just after the accept edge.
    task automatic issue(input bit sel, input bit wr, input logic [20:0] addr,
                         input logic [31:0] data, input bit wait_done, input bit scramble);
        int n;
        exp_t e;
        if (!sel) begin
            a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = data[15:0];
            iss_a++;
        end else begin
            b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = data;
        end
        n = 0;
        while (!(sel ? b_ready : a_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            a_valid = 1'b0;
            b_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!wr) begin
            e.data = sel ? data : {16'h0, data[15:0]};
            e.cyc  = cyc + (sel ? LAT_B : LAT_A);
            if (sel) sb_b.push_back(e);
            else     sb_a.push_back(e);
        end
        if (scramble && !sel) begin
            n = 0;
            while (n < 64) begin
                @(negedge clk);
                n++;
                if (!a_busy) break;
                a_addr  = 21'($urandom);
                a_wdata = 16'($urandom);
                a_write = 1'($urandom);
            end
            a_valid = 1'b0;
            if (n >= 64) check_eq("scramble_timeout", 32'd0, 32'd1);
        end else begin
            if (sel) b_valid = 1'b0;
            else     a_valid = 1'b0;
            if (wait_done) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while ((sel ? b_busy : a_busy) && n < 64);
                if (n >= 64) check_eq("done_timeout", 32'd0, 32'd1);
            end
        end
    endtask

    logic [7:0] b_exp_byte;

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_ready", 32'(a_ready), 32'd1);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check_eq("rst_rdata", 32'(a_rdata), 32'd0);
        check_eq("rst_addr", 32'(a_sram_addr), 32'd0);
        check_eq("rst_strobes", 32'({a_ce_n, a_we_n, a_oe_n}), 32'h7);
        check_eq("rst_drive", 32'(u_a.drive_q), 32'd0);
        check_eq("rst_b_ready", 32'(b_ready), 32'd1);

        rst = 1'b0;
        @(negedge clk);

        // Basic write/read round trip with latency via the scoreboard.
        issue(1'b0, 1'b1, 21'h00010, 32'hBEEF, 1'b1, 1'b0);
        check_eq("mem_10", 32'(mem_a[21'h00010]), 32'hEF);
        check_eq("mem_11", 32'(mem_a[21'h00011]), 32'hBE);
        issue(1'b0, 1'b0, 21'h00010, 32'hBEEF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("rdata_hold", 32'(a_rdata), 32'hBEEF);

        // Address wrap within a word.
        issue(1'b0, 1'b1, 21'h1FFFFF, 32'hCAFE, 1'b1, 1'b0);
        check_eq("mem_wrap_hi", 32'(mem_a[21'h1FFFFF]), 32'hFE);
        check_eq("mem_wrap_lo", 32'(mem_a[21'h000000]), 32'hCA);
        issue(1'b0, 1'b0, 21'h1FFFFF, 32'hCAFE, 1'b1, 1'b0);

        // 32-bit no-wait write, then a read held pending through the turnaround.
        issue(1'b1, 1'b1, 21'h00100, 32'h01234567, 1'b0, 1'b0);
        b_valid = 1'b1; b_write = 1'b0; b_addr = 21'h00100; b_wdata = 32'hFFFF_FFFF;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                b_exp_byte = (c == 1) ? 8'h67 : (c == 2) ? 8'h45 : (c == 3) ? 8'h23 : 8'h01;
                check_eq("b_beat_data", 32'(b_data), 32'(b_exp_byte));
                check_eq("b_beat_addr", 32'(b_sram_addr), 32'h100 + 32'(c - 1));
            end else if (c <= 6) begin
                check_eq("turn_ready", 32'(b_ready), 32'd0);
                check_eq("turn_ce_n", 32'(b_ce_n), 32'd1);
                check_eq("turn_drive", 32'(u_b.drive_q), 32'd0);
            end else begin
                check_eq("turn_done_ready", 32'(b_ready), 32'd1);
            end
        end
        issue(1'b1, 1'b0, 21'h00100, 32'h01234567, 1'b1, 1'b0);
        check_eq("mem_b_103", 32'(mem_b[21'h00103]), 32'h01);

        // Reset during beat 1 of a write.
        issue(1'b0, 1'b1, 21'h00040, 32'h1234, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_ce_n", 32'(a_ce_n), 32'd1);
        check_eq("mid_rst_we_n", 32'(a_we_n), 32'd1);
        check_eq("mid_rst_drive", 32'(u_a.drive_q), 32'd0);
        check_eq("mid_rst_ready", 32'(a_ready), 32'd1);
        check_eq("mid_rst_addr", 32'(a_sram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(1'b0, 1'b1, 21'h00040, 32'h1234, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 21'h00040, 32'h1234, 1'b1, 1'b0);

        // Request inputs churn while busy.
        issue(1'b0, 1'b1, 21'h00200, 32'hA55A, 1'b1, 1'b1);
        check_eq("mem_200", 32'(mem_a[21'h00200]), 32'h5A);
        check_eq("mem_201", 32'(mem_a[21'h00201]), 32'hA5);
        issue(1'b0, 1'b0, 21'h00200, 32'hA55A, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        check_eq("a_accepts", acc_a, iss_a);
        check_eq("sb_a_empty", sb_a.size(), 32'd0);
        check_eq("sb_b_empty", sb_b.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
